// File: rtl/apple1_pkg.sv
// Shared definitions for the apple1 memory arbiter: requester IDs and default limits.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package apple1_pkg;

    // Identity of the requester owning a RAM slot (or none).
    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } req_id_e;

    // Consecutive denied DMA cycles tolerated before DMA is forced a slot.
    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Width of the starvation counter; covers the legal limit range 1..15.
    localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles a requester is asserted but denied.
// Latency: count updates on the clock edge after each denied cycle; at_limit_o is combinational from the count.
// Backpressure: none; clears whenever the requester is granted or drops its request.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_i, gnt_i  request and grant of the watched requester
//   cnt_o         current count (0..LIMIT)
//   at_limit_o    high when the count has reached LIMIT
module arb_starve_counter
    import apple1_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    input  logic                    gnt_i,
    output logic [STARVE_CNT_W-1:0] cnt_o,
    output logic                    at_limit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT_V) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) single-port RAM arbiter, CPU priority with DMA starvation guard.
// Latency: grant and RAM strobe combinational; read data returns to the owner exactly 1 cycle later.
// Backpressure: a denied requester simply holds req; nothing is queued, reads pipeline every cycle.
//
// Ports:
//   clk25, rst                          clock and synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_gnt      CPU request side and its grant
//   cpu_rdata, cpu_rvalid               CPU read return
//   dma_*                               same set for the DMA requester
//   ram_en/we/addr/wdata, ram_rdata     RAM port (rdata valid the cycle after a read strobe)
module mem_arbiter
    import apple1_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk25,
    input  logic                  rst,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    req_id_e                 gnt_id;
    req_id_e                 owner_q;
    req_id_e                 owner_d;
    logic                    starve_hit;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q;
    logic [DATA_WIDTH-1:0]   dma_rdata_q;

    arb_starve_counter #(
        .LIMIT      (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk25),
        .rst        (rst),
        .req_i      (dma_req),
        .gnt_i      (dma_gnt),
        .cnt_o      (starve_cnt),
        .at_limit_o (starve_hit)
    );

    // Grant selection; nothing is granted while in reset so a read issued
    // in a reset cycle can never produce a return.
    always_comb begin
        gnt_id = NONE;
        if (!rst) begin
            if (cpu_req && dma_req) begin
                gnt_id = starve_hit ? DMA : CPU;
            end else if (cpu_req) begin
                gnt_id = CPU;
            end else if (dma_req) begin
                gnt_id = DMA;
            end
        end
    end

    assign cpu_gnt = (gnt_id == CPU);
    assign dma_gnt = (gnt_id == DMA);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (gnt_id)
            CPU: begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            DMA: begin
                ram_en    = 1'b1;
                ram_we    = dma_we;
                ram_addr  = dma_addr;
                ram_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    // Owner of the read issued this cycle; its data comes back next cycle.
    always_comb begin
        owner_d = NONE;
        if (ram_en && !ram_we) begin
            owner_d = gnt_id;
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            owner_q     <= NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (owner_q == CPU) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (owner_q == DMA) begin
                dma_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM data passes straight through in the return cycle; the held copy
    // keeps rdata stable once rvalid drops.
    assign cpu_rvalid = !rst && (owner_q == CPU);
    assign dma_rvalid = !rst && (owner_q == DMA);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? ram_rdata : dma_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 8: RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4: consecutive denied DMA cycles before DMA is forced a slot; legal range 1..15.
REQ-004 clk25  in  1  system clock; the block's only clock.
REQ-005 rst  in  1  reset; synchronous to clk25, active-high.
REQ-006 cpu_req  in  1  CPU requests an access this cycle.
REQ-007 cpu_we  in  1  CPU access is a write when high.
REQ-008 cpu_addr  in  ADDR_WIDTH  CPU address.
REQ-009 cpu_wdata  in  DATA_WIDTH  CPU write data.
REQ-010 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-011 cpu_rdata  out  DATA_WIDTH  CPU read data; valid only with cpu_rvalid.
REQ-012 cpu_rvalid  out  1  CPU read data valid.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rdata, dma_rvalid: same directions, widths and meanings as the cpu_* ports, for the DMA requester (serial loader / video fetch).
REQ-014 ram_en  out  1  RAM access strobe.
REQ-015 ram_we  out  1  RAM write enable.
REQ-016 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-017 ram_wdata  out  DATA_WIDTH  RAM write data.
REQ-018 ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after a read strobe.

Function
REQ-019 Grant is combinational: at most one of cpu_gnt/dma_gnt is high per cycle, and a grant is only issued to an asserted request.
REQ-020 Only req alone: that requester is granted.
REQ-021 Both req: CPU is granted unless starve_cnt == STARVE_LIMIT, in which case DMA is granted.
REQ-022 starve_cnt: resets to 0 whenever DMA is granted or dma_req is low; increments by 1 on each cycle dma_req is high and denied; saturates at STARVE_LIMIT.
REQ-023 In a granted cycle, ram_en=1 and ram_we/ram_addr/ram_wdata equal the granted requester's inputs; with no grant, ram_en=0, ram_we=0.
REQ-024 Read latency is exactly 1 cycle: a granted read in cycle N gives rvalid=1 to that requester only in cycle N+1, with rdata=ram_rdata.
REQ-025 Granted writes produce no rvalid.
REQ-026 Reads are pipelined: back-to-back grants are allowed every cycle, including alternating owners; each rvalid is routed to the owner of the read issued in the previous cycle.
REQ-027 A requester may drop req without having been granted; no state is retained for it apart from starve_cnt (REQ-022).
REQ-028 rdata outputs hold their last value when rvalid is low.

Reset
REQ-029 While rst is high: cpu_gnt=0, dma_gnt=0, ram_en=0, ram_we=0, cpu_rvalid=0, dma_rvalid=0, starve_cnt=0, read-owner pipeline register cleared.
REQ-030 A read granted in the cycle rst is asserted produces no rvalid in the following cycle.
REQ-031 The first grant is possible in the first cycle after rst deasserts.

Structure
REQ-032 Shared package apple1_pkg holds the requester-ID enumeration (NONE, CPU, DMA) and the default STARVE_LIMIT constant.
REQ-033 The saturating starvation counter is one sub-module, arb_starve_counter; all else is in mem_arbiter.

Verification
REQ-034 CPU reads 0x0200 (RAM holds 0xA5), no DMA -> cpu_gnt same cycle, cpu_rvalid=1 with cpu_rdata=0xA5 next cycle, dma_rvalid=0.
REQ-035 cpu_req and dma_req both held high continuously, STARVE_LIMIT=4 -> grant pattern CPU,CPU,CPU,CPU,DMA repeating.
REQ-036 Alternating grants: CPU reads 0x0010 (0x11), then DMA reads 0x0020 (0x22) in the next cycle -> cpu_rvalid/0x11 then dma_rvalid/0x22 on consecutive cycles, never crossed.
REQ-037 DMA writes 0x55 to 0xE000, then CPU reads 0xE000 -> cpu_rdata=0x55; no rvalid during the write cycle.
REQ-038 rst asserted in the cycle of a granted CPU read -> cpu_rvalid stays 0; all outputs at reset values; normal grant in the first post-reset cycle.
REQ-039 dma_req high 3 cycles while denied, then dropped for 1 cycle, then reasserted with cpu_req high -> starve_cnt restarts at 0; DMA granted only after 4 further denied cycles.
